// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port round-robin arbiter and access sequencer in front of a single-ported
// word memory. The instruction-fetch port (read-only) and the data port
// (read/write) share the memory. Each accepted request walks through
// IDLE -> ACCESS -> RESP. A watchdog bounds how long a read waits for mem_valid.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   imem_req/addr         : fetch request, held until imem_ready
//   imem_ready            : fetch request accepted this cycle (combinational)
//   imem_resp_*           : one-cycle fetch response (data, err)
//   dmem_req/cmd/addr/mask/write_data : data request, held until dmem_ready
//   dmem_ready            : data request accepted this cycle (combinational)
//   dmem_resp_*           : one-cycle data response (data, err)
//   mem_addr/mask/enable/cmd/write_data : memory request, active in ACCESS only
//   mem_load_data, mem_valid            : memory read return
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        imem_ready,
    output logic        imem_resp_valid,
    output logic [31:0] imem_resp_data,
    output logic        imem_resp_err,
    input  logic        dmem_req,
    input  logic        dmem_cmd,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_mask,
    input  logic [31:0] dmem_write_data,
    output logic        dmem_ready,
    output logic        dmem_resp_valid,
    output logic [31:0] dmem_resp_data,
    output logic        dmem_resp_err,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic        mem_enable,
    output logic        mem_cmd,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_load_data,
    input  logic        mem_valid
);

    localparam logic MEM_CMD_READ  = 1'b0;
    localparam logic MEM_CMD_WRITE = 1'b1;
    localparam logic PORT_IMEM     = 1'b0;
    localparam logic PORT_DMEM     = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Byte enables expanded to a 32-bit bit mask (bit i of mask covers byte i).
    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        logic [31:0] res;
        res = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = {8{m[i]}};
        end
        return res;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic              last_grant_r;
    logic              port_r;
    logic [31:0]       addr_r;
    logic              cmd_r;
    logic [3:0]        mask_r;
    logic [31:0]       wdata_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       rdata_r;
    logic              err_r;

    logic              grant_imem_s;
    logic              grant_dmem_s;
    logic              misaligned_s;
    logic              timeout_hit_s;
    logic              in_access_s;
    logic              in_resp_s;

    // Round-robin grant: only in IDLE, a tie goes to the port not granted last.
    always_comb begin
        grant_imem_s = 1'b0;
        grant_dmem_s = 1'b0;
        if ((state_r == ST_IDLE) && !reset) begin
            if (imem_req && dmem_req) begin
                if (last_grant_r == PORT_DMEM) begin
                    grant_imem_s = 1'b1;
                end else begin
                    grant_dmem_s = 1'b1;
                end
            end else if (imem_req) begin
                grant_imem_s = 1'b1;
            end else if (dmem_req) begin
                grant_dmem_s = 1'b1;
            end else begin
                grant_imem_s = 1'b0;
                grant_dmem_s = 1'b0;
            end
        end else begin
            grant_imem_s = 1'b0;
            grant_dmem_s = 1'b0;
        end
    end

    assign imem_ready    = grant_imem_s;
    assign dmem_ready    = grant_dmem_s;
    // A misaligned fetch is answered with an error without touching memory.
    assign misaligned_s  = grant_imem_s && (imem_addr[1:0] != 2'b00);
    // Counter counts missed ACCESS cycles; reaching TIMEOUT-1 means this is
    // the TIMEOUT-th ACCESS cycle.
    assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));
    assign in_access_s   = (state_r == ST_ACCESS);
    assign in_resp_s     = (state_r == ST_RESP);

    // Next-state logic of the request/response sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_imem_s || grant_dmem_s) begin
                    if (misaligned_s) begin
                        state_next_s = ST_RESP;
                    end else begin
                        state_next_s = ST_ACCESS;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if ((cmd_r == MEM_CMD_WRITE) || mem_valid || timeout_hit_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request capture, timeout counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= PORT_DMEM;
            port_r       <= PORT_IMEM;
            addr_r       <= 32'h0000_0000;
            cmd_r        <= MEM_CMD_READ;
            mask_r       <= 4'h0;
            wdata_r      <= 32'h0000_0000;
            cnt_r        <= {CNT_W{1'b0}};
            rdata_r      <= 32'h0000_0000;
            err_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_imem_s) begin
                        last_grant_r <= PORT_IMEM;
                        port_r       <= PORT_IMEM;
                        addr_r       <= imem_addr;
                        cmd_r        <= MEM_CMD_READ;
                        mask_r       <= 4'hF;
                        wdata_r      <= 32'h0000_0000;
                        cnt_r        <= {CNT_W{1'b0}};
                        rdata_r      <= 32'h0000_0000;
                        err_r        <= misaligned_s;
                    end else if (grant_dmem_s) begin
                        last_grant_r <= PORT_DMEM;
                        port_r       <= PORT_DMEM;
                        addr_r       <= dmem_addr;
                        cmd_r        <= dmem_cmd;
                        mask_r       <= dmem_mask;
                        wdata_r      <= dmem_write_data;
                        cnt_r        <= {CNT_W{1'b0}};
                        rdata_r      <= 32'h0000_0000;
                        err_r        <= 1'b0;
                    end else begin
                        cnt_r        <= cnt_r;
                    end
                end
                ST_ACCESS: begin
                    if (cmd_r == MEM_CMD_WRITE) begin
                        rdata_r <= 32'h0000_0000;
                        err_r   <= 1'b0;
                    end else if (mem_valid) begin
                        rdata_r <= mem_load_data;
                        err_r   <= 1'b0;
                    end else if (timeout_hit_s) begin
                        rdata_r <= 32'h0000_0000;
                        err_r   <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    rdata_r <= rdata_r;
                end
                default: begin
                    rdata_r <= rdata_r;
                end
            endcase
        end
    end

    // Memory request is driven only while in ACCESS. Unmasked bytes are forced
    // to zero because the memory ORs write data into cleared bytes.
    assign mem_enable     = in_access_s;
    assign mem_addr       = in_access_s ? addr_r : 32'h0000_0000;
    assign mem_cmd        = in_access_s ? cmd_r : MEM_CMD_READ;
    assign mem_mask       = in_access_s ? mask_r : 4'h0;
    assign mem_write_data = in_access_s ? (wdata_r & expand_mask(mask_r)) : 32'h0000_0000;

    // Responses are visible only in RESP and only on the port that owns it.
    assign imem_resp_valid = in_resp_s && (port_r == PORT_IMEM);
    assign imem_resp_data  = imem_resp_valid ? rdata_r : 32'h0000_0000;
    assign imem_resp_err   = imem_resp_valid ? err_r : 1'b0;
    assign dmem_resp_valid = in_resp_s && (port_r == PORT_DMEM);
    assign dmem_resp_data  = dmem_resp_valid ? rdata_r : 32'h0000_0000;
    assign dmem_resp_err   = dmem_resp_valid ? err_r : 1'b0;

endmodule
